// File: rtl/bitrev_sample_writer.sv
`timescale 1ns/1ps
// Streams one frame of 2**LOG2N samples into FFT RAM at bit-reversed addresses.
// Write lands one cycle after each accept; sample_ready stalls the source outside LOAD.
module bitrev_sample_writer #(
    parameter int LOG2N = 4,
    parameter int DW    = 16
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DW-1:0]    sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr,
    output logic [DW-1:0]    wr_data,
    output logic             busy,
    output logic             tc
);

    localparam logic [LOG2N-1:0] LAST = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LOG2N-1:0] cnt;
    logic             accept;
    logic             last_accept;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] i);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = i[LOG2N-1-b];
        end
        return r;
    endfunction

    assign accept      = sample_valid & sample_ready;
    assign last_accept = accept & (cnt == LAST);

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sample_ready = 1'b0;
        busy         = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                sample_ready = 1'b1;
                busy         = 1'b1;
                if (sample_valid && (cnt == LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Final write and tc are on the registered outputs this cycle.
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            tc      <= 1'b0;
        end else begin
            wr_en <= accept;
            tc    <= last_accept;
            if (accept) begin
                wr_data <= sample_in;
                wr_addr <= bitrev(cnt);
                cnt     <= cnt + 1'b1;
            end else if ((state == IDLE) && start) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bitrev_sample_writer.sv
`timescale 1ns/1ps
// Scoreboarded bench: each driven sample queues its expected write, checked on the write cycle.
module tb_bitrev_sample_writer;

    localparam int LOG2N = 4;
    localparam int DW    = 16;
    localparam int N     = 16;

    logic             Clk = 1'b0;
    logic             reset;
    logic             start;
    logic [DW-1:0]    sample_in;
    logic             sample_valid;
    logic             sample_ready;
    logic             wr_en;
    logic [LOG2N-1:0] wr_addr;
    logic [DW-1:0]    wr_data;
    logic             busy;
    logic             tc;

    bitrev_sample_writer #(.LOG2N(LOG2N), .DW(DW)) dut (
        .Clk          (Clk),
        .reset        (reset),
        .start        (start),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .tc           (tc)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int             idx;
        logic [LOG2N-1:0] addr;
    } vec_t;

    typedef struct {
        logic [LOG2N-1:0] addr;
        logic [DW-1:0]    data;
        logic             tc;
        int               cyc;
    } exp_t;

    vec_t tab[N];
    int   ref_addr[N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   tc_seen = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (wr_en) begin
                if (tc) tc_seen++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr_en actual addr=%0h data=%0h required no write (t=%0t)",
                             wr_addr, wr_data, $time);
                end else begin
                    e = sb.pop_front();
                    chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(wr_data), 32'(e.data));
                    chk("wr_tc", 32'(tc), 32'(e.tc));
                    chk("wr_cycle", cyc, e.cyc);
                end
            end else if (tc) begin
                checks++;
                errors++;
                $display("FAIL tc_without_wr_en actual tc=1 required tc=0 (t=%0t)", $time);
            end
        end
    end

    task automatic do_start(input bit now);
        if (!now) @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ready_in_load", 32'(sample_ready), 32'd1);
    endtask

    task automatic send_frame(input bit gaps, input int restart_at, input int count, input int base);
        exp_t x;
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                sample_valid = 1'b0;
                @(negedge Clk);
            end
            chk("ready_before_sample", 32'(sample_ready), 32'd1);
            sample_valid = 1'b1;
            sample_in    = DW'(base + tab[i].idx);
            start        = (i == restart_at);
            x.addr = tab[i].addr;
            x.data = DW'(base + tab[i].idx);
            x.tc   = (i == N - 1);
            x.cyc  = cyc + 1;
            sb.push_back(x);
            @(negedge Clk);
            start = 1'b0;
        end
        sample_valid = 1'b0;
        if (count == N) begin
            #1;
            chk("frame_drained", sb.size(), 0);
            chk("busy_in_done", 32'(busy), 32'd1);
            chk("ready_in_done", 32'(sample_ready), 32'd0);
            chk("tc_in_done", 32'(tc), 32'd1);
            @(negedge Clk);
            #1;
            chk("busy_after_done", 32'(busy), 32'd0);
            chk("wr_en_after_done", 32'(wr_en), 32'd0);
            chk("tc_after_done", 32'(tc), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            tab[i].idx  = i;
            tab[i].addr = LOG2N'(ref_addr[i]);
        end
        reset        = 1'b1;
        start        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;

        // Reset state.
        #20;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_tc", 32'(tc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(sample_ready), 32'd0);
        #82;
        reset = 1'b0;
        @(negedge Clk);
        chk("post_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("post_rst_wr_data", 32'(wr_data), 32'd0);
        chk("post_rst_ready", 32'(sample_ready), 32'd0);

        // Valid samples in IDLE must not be consumed.
        sample_valid = 1'b1;
        sample_in    = 16'hAAAA;
        repeat (3) begin
            @(negedge Clk);
            chk("idle_no_write", 32'(wr_en), 32'd0);
            chk("idle_not_ready", 32'(sample_ready), 32'd0);
        end
        sample_valid = 1'b0;

        // Continuous frame.
        do_start(1'b0);
        send_frame(1'b0, -1, N, 0);
        chk("tc_count_frame1", tc_seen, 1);

        // Stalled every other cycle.
        do_start(1'b0);
        send_frame(1'b1, -1, N, 0);
        chk("tc_count_frame2", tc_seen, 2);

        // start mid-frame is ignored.
        do_start(1'b0);
        send_frame(1'b0, 5, N, 16'h100);

        // Async reset after 7 accepts.
        do_start(1'b0);
        send_frame(1'b0, -1, 7, 16'h200);
        #1;
        chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_wr_en", 32'(wr_en), 32'd0);
        chk("async_rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("async_rst_wr_data", 32'(wr_data), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ready", 32'(sample_ready), 32'd0);
        sb.delete();
        @(posedge Clk);
        #2;
        reset = 1'b0;
        do_start(1'b0);
        send_frame(1'b0, -1, N, 16'h300);

        // Back-to-back frames, second start in the first IDLE cycle.
        do_start(1'b0);
        send_frame(1'b0, -1, N, 16'h400);
        do_start(1'b1);
        send_frame(1'b0, -1, N, 16'h500);

        repeat (3) @(negedge Clk);
        chk("tc_total", tc_seen, 6);
        chk("sb_empty_end", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
